// File: rtl/packed_struct_pkg.sv
// Shared types for the packed-struct path: the 16-bit word layout and the pad byte
// used when a partial pair is flushed out.
package packed_struct_pkg;

   typedef struct packed {
      logic [7:0] byte1;
      logic [7:0] byte2;
   } my_packed_struct_t;

   localparam logic [7:0] PAD_BYTE = 8'h00;

endpackage

// File: rtl/packed_word_slot.sv
// Single-entry valid/ready output register: loads a word, holds it while stalled,
// and releases it on handoff. A load in the handoff cycle keeps the slot full.
module packed_word_slot
   import packed_struct_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  my_packed_struct_t load_word,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [15:0]       out_word,
   output logic              slot_free,
   output logic              handoff
);

   logic              valid_q;
   my_packed_struct_t word_q;

   assign out_valid = valid_q;
   assign out_word  = word_q;
   assign slot_free = !valid_q || out_ready;
   assign handoff   = valid_q && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         word_q  <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         word_q  <= load_word;
      end else if (handoff) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/packed_struct_packer.sv
// Byte-to-word packer: pairs consecutive bytes into {byte1, byte2} words.
// Optional macro PACKER_FLUSH_EN adds flush_req/flush_ack to push out a partial pair.
module packed_struct_packer
   import packed_struct_pkg::*;
#(
   parameter int CNT_W = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_byte,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_word,
   output logic [CNT_W-1:0] word_count
`ifdef PACKER_FLUSH_EN
   ,
   input  logic             flush_req,
   output logic             flush_ack
`endif
);

   logic              half_q;
   logic [7:0]        hold_q;
   logic              slot_free;
   logic              handoff;
   logic              accept;
   logic              flush_load;
   logic              load;
   my_packed_struct_t load_word;

`ifdef PACKER_FLUSH_EN
   logic flush_go;
   logic flush_ack_q;

   // The ack guard stops a still-high flush_req from being acknowledged twice.
   assign flush_go   = flush_req && !flush_ack_q && (!half_q || slot_free);
   assign flush_load = flush_go && half_q;
   assign in_ready   = !flush_req && (!half_q || slot_free);
   assign flush_ack  = flush_ack_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) flush_ack_q <= 1'b0;
      else     flush_ack_q <= flush_go;
   end
`else
   assign flush_load = 1'b0;
   assign in_ready   = !half_q || slot_free;
`endif

   assign accept = in_valid && in_ready;
   assign load   = (accept && half_q) || flush_load;

   always_comb begin
      load_word.byte1 = hold_q;
      load_word.byte2 = flush_load ? PAD_BYTE : in_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             half_q <= 1'b0;
      else if (flush_load) half_q <= 1'b0;
      else if (accept)     half_q <= !half_q;
   end

   // Held byte needs no reset: half_q alone says whether it is meaningful.
   always_ff @(posedge clk) begin
      if (accept && !half_q) hold_q <= in_byte;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          word_count <= '0;
      else if (handoff) word_count <= word_count + CNT_W'(1);
   end

   packed_word_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_word (load_word),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_word  (out_word),
      .slot_free (slot_free),
      .handoff   (handoff)
   );

endmodule

// File: tb/tb_packed_struct_packer.sv
// Scoreboard bench for packed_struct_packer: bytes are paired in a queue model,
// and a monitor compares every presented word, ready and counter value.
module tb_packed_struct_packer;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_byte;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_word;
   logic [CNT_W-1:0] word_count;
`ifdef PACKER_FLUSH_EN
   logic             flush_req;
   logic             flush_ack;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int rmode       = 1;

   logic [15:0] exp_q[$];
   logic [15:0] outlog[$];
   logic        mhalf = 1'b0;
   logic [7:0]  mhold = 8'h00;
   int          mcount = 0;
   int          valid_cycles = 0;
   int          irlow_cycles = 0;
   logic        exp_ir;

   packed_struct_packer #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_byte    (in_byte),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_word   (out_word),
      .word_count (word_count)
`ifdef PACKER_FLUSH_EN
      ,
      .flush_req  (flush_req),
      .flush_ack  (flush_ack)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: reference model is a byte-pairing queue of words awaiting handoff.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_out_valid", out_valid, 0);
         check("rst_out_word", out_word, 16'h0000);
         check("rst_word_count", word_count, 0);
         check("rst_in_ready", in_ready, 1);
         exp_q.delete();
         outlog.delete();
         mhalf  = 1'b0;
         mcount = 0;
      end else begin
`ifdef PACKER_FLUSH_EN
         if (flush_ack && mhalf) begin
            exp_q.push_back({mhold, 8'h00});
            mhalf = 1'b0;
         end
`endif
         check("word_count", word_count, mcount % (1 << CNT_W));
         check("out_valid", out_valid, exp_q.size() > 0);
         if (out_valid && exp_q.size() > 0) check("out_word", out_word, exp_q[0]);
         exp_ir = !mhalf || (exp_q.size() == 0) || out_ready;
`ifdef PACKER_FLUSH_EN
         if (flush_req) exp_ir = 1'b0;
`endif
         check("in_ready", in_ready, exp_ir);
         if (out_valid) valid_cycles++;
         if (!in_ready) irlow_cycles++;
         if (out_valid && out_ready && exp_q.size() > 0) begin
            outlog.push_back(out_word);
            void'(exp_q.pop_front());
            mcount++;
         end
         if (in_valid && in_ready) begin
            if (!mhalf) begin
               mhold = in_byte;
               mhalf = 1'b1;
            end else begin
               exp_q.push_back({mhold, in_byte});
               mhalf = 1'b0;
            end
         end
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rmode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_byte  = b;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 1000) begin
            check("send_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

`ifdef PACKER_FLUSH_EN
   task automatic do_flush(output logic v, output logic [15:0] w);
      int n = 0;
      v = 1'b0;
      w = 16'h0;
      flush_req = 1'b1;
      forever begin
         @(negedge clk);
         if (flush_ack) begin
            v = out_valid;
            w = out_word;
            break;
         end
         n++;
         if (n > 100) begin
            check("flush_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      flush_req = 1'b0;
      @(negedge clk);
      check("flush_ack_pulse", flush_ack, 0);
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      logic [15:0] t2_exp [4];
      t2_exp = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
      rst      = 1'b1;
      in_valid = 1'b0;
      in_byte  = 8'h00;
`ifdef PACKER_FLUSH_EN
      flush_req = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // First pair after reset
      rmode = 1;
      valid_cycles = 0;
      send_byte(8'hA5);
      send_byte(8'h3C);
      idle(4);
      check("t1_nwords", outlog.size(), 1);
      if (outlog.size() >= 1) check("t1_word", outlog[0], 16'hA53C);
      check("t1_valid_cycles", valid_cycles, 1);
      check("t1_word_count", word_count, 1);

      // Back-to-back bytes at full rate
      outlog.delete();
      irlow_cycles = 0;
      valid_cycles = 0;
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      idle(3);
      check("t2_nwords", outlog.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < outlog.size()) check("t2_word", outlog[i], t2_exp[i]);
      check("t2_in_ready_low", irlow_cycles, 0);
      check("t2_valid_cycles", valid_cycles, 4);

      // Stalled consumer: byte1 of the next pair accepted, byte2 held off
      outlog.delete();
      rmode = 0;
      idle(1);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      in_valid = 1'b1;
      in_byte  = 8'h44;
      repeat (3) begin
         @(negedge clk);
         check("t3_in_ready_stall", in_ready, 0);
         check("t3_held_word", out_word, 16'h1122);
         check("t3_held_valid", out_valid, 1);
      end
      rmode = 1;
      send_byte(8'h44);
      idle(4);
      check("t3_nwords", outlog.size(), 2);
      if (outlog.size() >= 2) begin
         check("t3_word0", outlog[0], 16'h1122);
         check("t3_word1", outlog[1], 16'h3344);
      end

      // Counter wrap after 2^CNT_W words
      do_reset();
      rmode = 1;
      for (int i = 0; i < 2 * (1 << CNT_W); i++) send_byte(8'($urandom));
      idle(3);
      check("t4_wrap_zero", word_count, 0);
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      idle(3);
      check("t4_wrap_one", word_count, 1);

      // Asynchronous reset mid-pair discards the held byte
      send_byte(8'hFF);
      do_reset();
      send_byte(8'h12);
      send_byte(8'h34);
      idle(3);
      check("t5_nwords", outlog.size(), 1);
      if (outlog.size() >= 1) check("t5_word", outlog[0], 16'h1234);

      // Random traffic with random backpressure
      rmode = 2;
      for (int i = 0; i < 400; i++) begin
         send_byte(8'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      if (mhalf) send_byte(8'($urandom));
      rmode = 1;
      idle(6);
      check("t6_drained", exp_q.size(), 0);

`ifdef PACKER_FLUSH_EN
      begin
         logic        fv;
         logic [15:0] fw;
         do_reset();
         rmode = 1;
         send_byte(8'h9A);
         do_flush(fv, fw);
         check("t7_flush_valid", fv, 1);
         check("t7_flush_word", fw, 16'h9A00);
         idle(3);
         check("t7_nwords", outlog.size(), 1);
         if (outlog.size() >= 1) check("t7_word", outlog[0], 16'h9A00);
         outlog.delete();
         do_flush(fv, fw);
         check("t7_empty_flush_valid", fv, 0);
         idle(3);
         check("t7_empty_nwords", outlog.size(), 0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
